// File: rtl/bennett_clock_monitor.sv
// Decodes and checks the Bennett clock generator's phase rails (clkp/clkn).
// Latency: 2 clk from a rail change to the registered outputs (input register + output register).
// Backpressure: none; a passive monitor that accepts one rail sample on every clk.
//
// Ports:
//   clk, reset        posedge clock, synchronous active-high reset
//   clkp, clkn        WIDTH-bit phase rails from the generator
//   phase_idx         decoded ramp level k (0..WIDTH), holds its last legal value
//   rising, falling   ramp direction (state RISE / FALL)
//   cycle_done        1-clk pulse when a full ramp returns to k=0
//   cycle_count       completed ramps, wraps silently
//   err_complement    sticky: clkn was not the bitwise inverse of clkp
//   err_order         sticky: non-thermometer pattern or illegal step
//   err_timeout       sticky: level stalled for more than TIMEOUT samples while ramping
module bennett_clock_monitor #(
    parameter int WIDTH   = 13,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16,
    localparam int KW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clkp,
    input  logic [WIDTH-1:0] clkn,
    output logic [KW-1:0]    phase_idx,
    output logic             rising,
    output logic             falling,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_complement,
    output logic             err_order,
    output logic             err_timeout
);

    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        IDLE  = 3'd1,
        RISE  = 3'd2,
        FALL  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s_p, s_n;
    // s_vld masks the reset-cleared s_p/s_n, which would otherwise look like
    // a complement fault and a drained bus on the first edge after reset.
    logic             s_vld;
    logic [SW-1:0]    stall, stall_nxt;

    logic [KW-1:0]    idx_nxt;
    logic             rise_nxt, fall_nxt, done_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ec_nxt, eo_nxt, et_nxt;

    // Decode of the registered sample
    logic [WIDTH:0]   sp_inc;
    logic             therm;
    logic [KW-1:0]    k;
    logic             k_same, k_up, k_dn;

    // A thermometer code plus one is a power of two, so it shares no set bit
    // with the original (all-ones carries out of the WIDTH bits entirely).
    assign sp_inc = {1'b0, s_p} + {{WIDTH{1'b0}}, 1'b1};
    assign therm  = (sp_inc[WIDTH-1:0] & s_p) == '0;

    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            k = k + KW'(s_p[i]);
        end
    end

    // phase_idx doubles as the previous legal level
    assign k_same = therm && (k == phase_idx);
    assign k_up   = therm && (k == phase_idx + KW'(1));
    assign k_dn   = therm && (phase_idx != '0) && (k == phase_idx - KW'(1));

    always_comb begin
        state_nxt = state;
        stall_nxt = stall;
        idx_nxt   = phase_idx;
        done_nxt  = 1'b0;
        cnt_nxt   = cycle_count;
        eo_nxt    = err_order;
        et_nxt    = err_timeout;
        ec_nxt    = err_complement | (s_vld && (s_n != ~s_p));

        if (s_vld) begin
            case (state)
                SYNC: begin
                    if (therm) idx_nxt = k;
                    if (s_p == '0) state_nxt = IDLE;
                end
                IDLE: begin
                    stall_nxt = '0;
                    if (!therm || k > KW'(1)) begin
                        state_nxt = ERROR;
                        eo_nxt    = 1'b1;
                    end else begin
                        idx_nxt = k;
                        if (k == KW'(1)) state_nxt = RISE;
                    end
                end
                RISE: begin
                    if (k_same) begin
                        if (stall == SW'(TIMEOUT)) begin
                            state_nxt = ERROR;
                            et_nxt    = 1'b1;
                        end else begin
                            stall_nxt = stall + SW'(1);
                        end
                    end else if (k_up) begin
                        idx_nxt   = k;
                        stall_nxt = '0;
                        if (k == KW'(WIDTH)) state_nxt = FALL;
                    end else begin
                        state_nxt = ERROR;
                        eo_nxt    = 1'b1;
                    end
                end
                FALL: begin
                    if (k_same) begin
                        if (stall == SW'(TIMEOUT)) begin
                            state_nxt = ERROR;
                            et_nxt    = 1'b1;
                        end else begin
                            stall_nxt = stall + SW'(1);
                        end
                    end else if (k_dn) begin
                        idx_nxt   = k;
                        stall_nxt = '0;
                        if (k == '0) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                            cnt_nxt   = cycle_count + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = ERROR;
                        eo_nxt    = 1'b1;
                    end
                end
                default: ;  // ERROR: absorbing, only the sticky flags move
            endcase
        end

        // Direction outputs freeze on entry to ERROR
        if (state_nxt == ERROR) begin
            rise_nxt = rising;
            fall_nxt = falling;
        end else begin
            rise_nxt = (state_nxt == RISE);
            fall_nxt = (state_nxt == FALL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_p            <= '0;
            s_n            <= '0;
            s_vld          <= 1'b0;
            state          <= SYNC;
            stall          <= '0;
            phase_idx      <= '0;
            rising         <= 1'b0;
            falling        <= 1'b0;
            cycle_done     <= 1'b0;
            cycle_count    <= '0;
            err_complement <= 1'b0;
            err_order      <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            s_p            <= clkp;
            s_n            <= clkn;
            s_vld          <= 1'b1;
            state          <= state_nxt;
            stall          <= stall_nxt;
            phase_idx      <= idx_nxt;
            rising         <= rise_nxt;
            falling        <= fall_nxt;
            cycle_done     <= done_nxt;
            cycle_count    <= cnt_nxt;
            err_complement <= ec_nxt;
            err_order      <= eo_nxt;
            err_timeout    <= et_nxt;
        end
    end

endmodule
